// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: coin credit FSM with vend strobe, nickel change and BCD digits.
// Optional display scan counter is built when VEND_DISP_SCAN_EN is defined.
module vend_credit_ctrl #(
    parameter int PRICE   = 65,
    parameter int REFRESH = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_n,
    input  logic       coin_d,
    input  logic       coin_q,
    input  logic       cancel,
    output logic       vend,
    output logic       change_n,
    output logic       coin_rej,
    output logic       coin_err,
    output logic [3:0] credit_tens,
    output logic [3:0] credit_ones,
    output logic       disp_sel
);

    localparam logic [4:0] PRICE_N = 5'(PRICE / 5);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] credit;
    logic [4:0] credit_next;
    logic [4:0] coin_val;
    logic       coin_any;
    logic       coin_multi;
    logic       rej_next;

    // Coin decode: quarter beats dime beats nickel.
    always_comb begin
        coin_any   = coin_n | coin_d | coin_q;
        coin_multi = (coin_n & coin_d) | (coin_n & coin_q) | (coin_d & coin_q);
        coin_val   = 5'd0;
        if (coin_q) begin
            coin_val = 5'd5;
        end else if (coin_d) begin
            coin_val = 5'd2;
        end else if (coin_n) begin
            coin_val = 5'd1;
        end
    end

    // Next state, next credit and reject flag.
    always_comb begin
        state_next  = state;
        credit_next = credit;
        rej_next    = 1'b0;
        unique case (state)
            IDLE, COLLECT: begin
                if (coin_any) begin
                    credit_next = credit + coin_val;
                end
                if (state == COLLECT && cancel) begin
                    state_next = CHANGE;
                end else if (coin_any) begin
                    state_next = (credit_next >= PRICE_N) ? VEND : COLLECT;
                end
            end
            VEND: begin
                credit_next = credit - PRICE_N;
                state_next  = (credit_next == 5'd0) ? IDLE : CHANGE;
                rej_next    = coin_any;
            end
            CHANGE: begin
                credit_next = credit - 5'd1;
                if (credit_next == 5'd0) begin
                    state_next = IDLE;
                end
                rej_next = coin_any;
            end
            default: begin
                state_next  = IDLE;
                credit_next = 5'd0;
            end
        endcase
    end

    // State, credit and registered coin status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= 5'd0;
            coin_rej <= 1'b0;
            coin_err <= 1'b0;
        end else begin
            state    <= state_next;
            credit   <= credit_next;
            coin_rej <= rej_next;
            coin_err <= coin_multi;
        end
    end

    // Moore strobes and BCD split of 5*credit (tens = credit/2, ones = 0 or 5).
    always_comb begin
        vend        = (state == VEND);
        change_n    = (state == CHANGE);
        credit_tens = credit[4:1];
        credit_ones = credit[0] ? 4'd5 : 4'd0;
    end

`ifdef VEND_DISP_SCAN_EN
    localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    logic [CW-1:0] refresh_cnt;

    // Free-running refresh counter; select flips on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            disp_sel    <= 1'b0;
        end else if (refresh_cnt == CW'(REFRESH - 1)) begin
            refresh_cnt <= '0;
            disp_sel    <= ~disp_sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end
`else
    assign disp_sel = 1'b0;
`endif

endmodule
